// File: rtl/mcoi_gbt_frame_capture_pkg.sv
// Shared types for the GBT frame capture block: control/status layouts, FSM states, serializer phases.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mcoi_gbt_frame_capture_pkg;

  localparam int GBT_CAP_WORDS_PER_FRAME = 3;

  // Clock/reset bundle; reset is active-low and sampled synchronously.
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} capture_state_t;

  // Serializer phase: which word of the held frame is on the BRAM port.
  typedef enum logic [1:0] {SER_IDLE, SER_P0, SER_P1, SER_P2} ser_phase_t;

  typedef struct packed {
    logic [15:0] trig_value;
    logic [11:0] depth;
    logic        rsvd;
    logic        trig_en;
    logic        abort;
    logic        arm;
  } capture_ctrl_t;

  typedef struct packed {
    logic [15:0] dropped;
    logic [11:0] frames_written;
    logic        overflow;
    logic        done;
    logic        capturing;
    logic        armed;
  } capture_status_t;

  // depth 0 or anything above the buffer size means "fill the whole buffer".
  function automatic logic [12:0] effective_depth(input logic [11:0] depth,
                                                  input logic [12:0] max_frames);
    if (depth == 12'd0 || {1'b0, depth} > max_frames) return max_frames;
    return {1'b0, depth};
  endfunction

endpackage

// File: rtl/mcoi_gbt_frame_capture_serializer.sv
// Splits one 84-bit frame into three 32-bit BRAM writes with running address and frame index.
// Latency: frame loaded at cycle t puts w0/w1/w2 on the port at t+1/t+2/t+3.
// Backpressure: ready only when idle or emitting the last word; loads while busy are ignored.
module mcoi_frame_serializer
  import mcoi_gbt_frame_capture_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        abort,
  input  logic        load,
  input  logic [83:0] data_i,
  output logic        ready_o,
  output logic        word_done_o,
  output logic        frame_done_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_addr_o,
  output logic [31:0] bram_din_o
);

  ser_phase_t  phase_q, phase_d;
  logic [83:0] frame_q, frame_d;
  logic [11:0] idx_q, idx_d;
  logic [11:0] next_idx_q, next_idx_d;
  logic [31:0] next_addr_q, next_addr_d;
  logic        en_q, en_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;

  assign ready_o      = (phase_q == SER_IDLE) || (phase_q == SER_P2);
  assign word_done_o  = (phase_q != SER_IDLE);
  assign frame_done_o = (phase_q == SER_P2);
  assign bram_en_o    = en_q;
  assign bram_we_o    = we_q;
  assign bram_addr_o  = addr_q;
  assign bram_din_o   = din_q;

  // Next phase and the registered write that goes with it; abort drops the rest of the frame.
  always_comb begin
    phase_d     = phase_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    next_idx_d  = next_idx_q;
    next_addr_d = next_addr_q;
    en_d        = 1'b0;
    we_d        = 4'h0;
    addr_d      = addr_q;
    din_d       = din_q;
    if (restart) begin
      next_idx_d  = 12'd0;
      next_addr_d = BASE_ADDR;
    end
    if (abort) begin
      phase_d = SER_IDLE;
    end else if (load && ready_o) begin
      phase_d     = SER_P0;
      frame_d     = data_i;
      idx_d       = next_idx_q;
      next_idx_d  = next_idx_q + 12'd1;
      en_d        = 1'b1;
      we_d        = 4'hF;
      addr_d      = next_addr_q;
      next_addr_d = next_addr_q + 32'd4;
      din_d       = data_i[31:0];
    end else begin
      case (phase_q)
        SER_P0: begin
          phase_d     = SER_P1;
          en_d        = 1'b1;
          we_d        = 4'hF;
          addr_d      = next_addr_q;
          next_addr_d = next_addr_q + 32'd4;
          din_d       = frame_q[63:32];
        end
        SER_P1: begin
          phase_d     = SER_P2;
          en_d        = 1'b1;
          we_d        = 4'hF;
          addr_d      = next_addr_q;
          next_addr_d = next_addr_q + 32'd4;
          din_d       = {idx_q, frame_q[83:64]};
        end
        SER_P2:  phase_d = SER_IDLE;
        default: phase_d = SER_IDLE;
      endcase
    end
  end

  // Registers; reset abandons any write and parks the port at BASE_ADDR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= SER_IDLE;
      frame_q     <= '0;
      idx_q       <= '0;
      next_idx_q  <= '0;
      next_addr_q <= BASE_ADDR;
      en_q        <= 1'b0;
      we_q        <= 4'h0;
      addr_q      <= BASE_ADDR;
      din_q       <= '0;
    end else begin
      phase_q     <= phase_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      next_idx_q  <= next_idx_d;
      next_addr_q <= next_addr_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

endmodule

// File: rtl/mcoi_gbt_frame_capture.sv
// Captures a window of received GBT frames into shared BRAM, armed/monitored via PS registers.
// Latency: trigger/accept at t gives first BRAM write at t+1; status/done registered, 1 cycle.
// Backpressure: none upstream; a frame arriving while the serializer is mid-frame is dropped and counted.
module mcoi_gbt_frame_capture
  import mcoi_gbt_frame_capture_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          MAX_FRAMES = 1024
) (
  input  ckrs_t       ClkRs_ix,
  input  logic [83:0] rx_data_i,
  input  logic        rx_valid_i,
  input  logic [31:0] control_i,
  output logic [31:0] status_o,
  output logic        done_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_addr_o,
  output logic [31:0] bram_din_o
);

  logic clk, rst_n;
  assign clk   = ClkRs_ix.clk;
  assign rst_n = ClkRs_ix.reset;

  capture_ctrl_t   ctrl;
  capture_state_t  state_q, state_d;
  capture_status_t status_q, status_d;
  logic [12:0]     frames_written_q, frames_written_d;
  logic [12:0]     accepted_q, accepted_d;
  logic [15:0]     dropped_q, dropped_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic            arm_prev_q, arm_prev_d;
  logic [12:0]     depth_eff;
  logic            arm_rise, trig_hit, ser_load, ser_restart;
  logic            ser_ready, ser_word_done, ser_frame_done;
  logic            unused_ok;

  assign ctrl      = capture_ctrl_t'(control_i);
  assign unused_ok = ctrl.rsvd ^ ser_word_done;
  assign depth_eff = effective_depth(ctrl.depth, 13'(MAX_FRAMES));
  assign arm_rise  = ctrl.arm && !arm_prev_q;
  assign trig_hit  = rx_valid_i && (!ctrl.trig_en || (rx_data_i[15:0] == ctrl.trig_value));
  assign status_o  = status_q;
  assign done_o    = done_q;

  // Capture FSM next state, counters and the status word they produce.
  always_comb begin
    state_d          = state_q;
    frames_written_d = frames_written_q;
    accepted_d       = accepted_q;
    dropped_d        = dropped_q;
    overflow_d       = overflow_q;
    done_d           = 1'b0;
    arm_prev_d       = ctrl.arm;
    ser_load         = 1'b0;
    ser_restart      = 1'b0;
    if (ctrl.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm_rise) begin
            state_d          = ARMED;
            ser_restart      = 1'b1;
            frames_written_d = '0;
            accepted_d       = '0;
            dropped_d        = '0;
            overflow_d       = 1'b0;
          end
        end
        ARMED: begin
          if (trig_hit && ser_ready) begin
            ser_load   = 1'b1;
            accepted_d = 13'd1;
            state_d    = CAPTURE;
          end
        end
        CAPTURE: begin
          // Frames beyond the requested depth are simply not wanted, so they are not drops.
          if (rx_valid_i && (accepted_q < depth_eff)) begin
            if (ser_ready) begin
              ser_load   = 1'b1;
              accepted_d = accepted_q + 13'd1;
            end else begin
              overflow_d = 1'b1;
              if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
            end
          end
          if (ser_frame_done) begin
            frames_written_d = frames_written_q + 13'd1;
            if (frames_written_d >= depth_eff) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    status_d.dropped        = dropped_d;
    status_d.frames_written = frames_written_d[11:0];
    status_d.overflow       = overflow_d;
    status_d.done           = (state_d == DONE);
    status_d.capturing      = (state_d == CAPTURE);
    status_d.armed          = (state_d == ARMED);
  end

  // FSM and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      status_q         <= '0;
      frames_written_q <= '0;
      accepted_q       <= '0;
      dropped_q        <= '0;
      overflow_q       <= 1'b0;
      done_q           <= 1'b0;
      arm_prev_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      status_q         <= status_d;
      frames_written_q <= frames_written_d;
      accepted_q       <= accepted_d;
      dropped_q        <= dropped_d;
      overflow_q       <= overflow_d;
      done_q           <= done_d;
      arm_prev_q       <= arm_prev_d;
    end
  end

  mcoi_frame_serializer #(
    .BASE_ADDR(BASE_ADDR)
  ) u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (ser_restart),
    .abort        (ctrl.abort),
    .load         (ser_load),
    .data_i       (rx_data_i),
    .ready_o      (ser_ready),
    .word_done_o  (ser_word_done),
    .frame_done_o (ser_frame_done),
    .bram_en_o    (bram_en_o),
    .bram_we_o    (bram_we_o),
    .bram_addr_o  (bram_addr_o),
    .bram_din_o   (bram_din_o)
  );

endmodule

// File: tb/tb_mcoi_gbt_frame_capture.sv
// Directed bench for mcoi_gbt_frame_capture with MAX_FRAMES=8 and BASE_ADDR=0.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 1 ns after the edge or on the falling edge.
// Backpressure: n/a.
module tb_mcoi_gbt_frame_capture;
  import mcoi_gbt_frame_capture_pkg::*;

  localparam logic [31:0] BASE = 32'h0;

  ckrs_t       ckrs;
  logic [83:0] rx_data;
  logic        rx_valid;
  logic [31:0] ctrl_w;
  logic [31:0] status_o;
  logic        done_o, bram_en_o;
  logic [3:0]  bram_we_o;
  logic [31:0] bram_addr_o, bram_din_o;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int we_bad   = 0;
  bit mon_on   = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_dat[$];
  logic [83:0] sent[$];

  mcoi_gbt_frame_capture #(.BASE_ADDR(BASE), .MAX_FRAMES(8)) dut (
    .ClkRs_ix(ckrs), .rx_data_i(rx_data), .rx_valid_i(rx_valid), .control_i(ctrl_w),
    .status_o(status_o), .done_o(done_o), .bram_en_o(bram_en_o), .bram_we_o(bram_we_o),
    .bram_addr_o(bram_addr_o), .bram_din_o(bram_din_o)
  );

  initial begin
    ckrs.clk = 1'b0;
    forever #5 ckrs.clk = ~ckrs.clk;
  end

  // BRAM port and done_o monitor.
  always @(negedge ckrs.clk) begin
    if (mon_on) begin
      if (bram_en_o === 1'b1) begin
        wr_addr.push_back(bram_addr_o);
        wr_dat.push_back(bram_din_o);
      end
      if ((bram_en_o === 1'b1 && bram_we_o !== 4'hF) || (bram_en_o === 1'b0 && bram_we_o !== 4'h0))
        we_bad++;
      if (done_o === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge ckrs.clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_word(input logic [83:0] d, input int n, input int k);
    logic [31:0] nn;
    nn = n;
    case (k)
      0:       return d[31:0];
      1:       return d[63:32];
      default: return {nn[11:0], d[83:64]};
    endcase
  endfunction

  // Presents one frame for a single cycle, then idles two cycles (1-in-3 cadence).
  task automatic send(input logic [83:0] d, input bit captured);
    rx_data = d;
    rx_valid = 1'b1;
    if (captured) sent.push_back(d);
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_dat.delete();
    sent.delete();
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_nwr"}, wr_addr.size(), 3 * sent.size());
    for (int i = 0; i < wr_addr.size() && i < 3 * sent.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], BASE + 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), wr_dat[i], exp_word(sent[i / 3], i / 3, i % 3));
    end
  endtask

  // Drops arm, then raises it with a new control setting to get a clean rising edge.
  task automatic rearm(input logic [15:0] tv, input logic [11:0] dep, input logic ten);
    ctrl_w[0] = 1'b0;
    tick();
    ctrl_w = {tv, dep, 1'b0, ten, 1'b0, 1'b1};
    tick();
  endtask

  initial begin
    logic [83:0] fx, fy, fz;
    ckrs.reset = 1'b0;
    ctrl_w = '0;
    rx_valid = 1'b0;
    rx_data = '0;
    tick();
    mon_on = 1;
    tick();
    tick();
    chk("rst_en", 32'(bram_en_o), 32'h0);
    chk("rst_we", 32'(bram_we_o), 32'h0);
    chk("rst_addr", bram_addr_o, BASE);
    chk("rst_din", bram_din_o, 32'h0);
    chk("rst_status", status_o, 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    ckrs.reset = 1'b1;
    tick();

    // Free-running capture of four frames.
    clear_log();
    rearm(16'h0, 12'd4, 1'b0);
    chk("t1_armed", status_o, 32'h1);
    rx_data = 84'h1;
    rx_valid = 1'b1;
    sent.push_back(84'h1);
    tick();
    rx_valid = 1'b0;
    chk("t1_w0_en", 32'(bram_en_o), 32'h1);
    chk("t1_w0_addr", bram_addr_o, 32'h0);
    chk("t1_w0_din", bram_din_o, 32'h1);
    chk("t1_capturing", status_o, 32'h2);
    tick();
    tick();
    for (int i = 2; i <= 4; i++) send(84'(i), 1'b1);
    chk("t1_done_pre", 32'(done_o), 32'h0);
    tick();
    chk("t1_done_pulse", 32'(done_o), 32'h1);
    chk("t1_status", status_o, 32'h0000_0044);
    tick();
    chk("t1_done_low", 32'(done_o), 32'h0);
    chk("t1_done_cnt", done_cnt, 32'd1);
    chk("t1_w2_f2", wr_dat[8], 32'h0020_0000);
    check_words("t1");

    // Pattern trigger: non-matching frames are ignored.
    clear_log();
    rearm(16'hA5A5, 12'd1, 1'b1);
    chk("t2_armed", status_o, 32'h1);
    send(84'h1234, 1'b0);
    send(84'hA5A4, 1'b0);
    chk("t2_no_writes", wr_addr.size(), 32'd0);
    chk("t2_still_armed", status_o, 32'h1);
    send({20'hABCDE, 32'h1234_5678, 32'h9ABC_A5A5}, 1'b1);
    tick();
    chk("t2_status", status_o, 32'h0000_0014);
    chk("t2_w0", wr_dat[0], 32'h9ABC_A5A5);
    chk("t2_w2", wr_dat[2], 32'h000A_BCDE);
    check_words("t2");

    // Overflow: second of two back-to-back frames is dropped.
    clear_log();
    rearm(16'h0, 12'd2, 1'b0);
    fx = {20'h00111, 32'h2222_2222, 32'h3333_3333};
    fy = {20'h0DEAD, 32'hDEAD_DEAD, 32'hDEAD_DEAD};
    fz = {20'hFFFFF, 32'h4444_4444, 32'h5555_5555};
    rx_data = fx;
    rx_valid = 1'b1;
    sent.push_back(fx);
    tick();
    rx_data = fy;
    tick();
    rx_valid = 1'b0;
    chk("t3_drop_status", status_o, 32'h0001_000A);
    tick();
    send(fz, 1'b1);
    tick();
    chk("t3_status", status_o, 32'h0001_002C);
    chk("t3_z_w2", wr_dat[5], 32'h001F_FFFF);
    check_words("t3");

    // Abort while w1 is on the port.
    clear_log();
    rearm(16'h0, 12'd4, 1'b0);
    chk("t4_armed_clr", status_o, 32'h1);
    rx_data = {20'h77777, 32'h6666_6666, 32'h5555_0000};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("t4_w1_on_port", bram_din_o, 32'h6666_6666);
    ctrl_w[1] = 1'b1;
    tick();
    chk("t4_en_off", 32'(bram_en_o), 32'h0);
    chk("t4_status_idle", status_o, 32'h0);
    chk("t4_done", 32'(done_o), 32'h0);
    tick();
    tick();
    tick();
    ctrl_w[1] = 1'b0;
    tick();
    chk("t4_nwr", wr_addr.size(), 32'd2);
    chk("t4_status_after", status_o, 32'h0);

    // depth=0 selects the full 8-frame buffer.
    clear_log();
    rearm(16'h0, 12'd0, 1'b0);
    for (int i = 0; i < 8; i++) send({20'(i * 3 + 1), 32'hC0DE_0000 + 32'(i), 32'(i + 100)}, 1'b1);
    tick();
    chk("t5_status", status_o, 32'h0000_0084);
    check_words("t5");

    // depth above the buffer clamps to 8; re-arm restarts at BASE with cleared counters.
    clear_log();
    rearm(16'h0, 12'hFFF, 1'b0);
    chk("t6_rearm_clr", status_o, 32'h1);
    for (int i = 0; i < 8; i++) send({20'(i + 500), 32'hBEEF_0000 + 32'(i), 32'(i * 7)}, 1'b1);
    tick();
    chk("t6_status", status_o, 32'h0000_0084);
    check_words("t6");

    // Reset in the middle of a frame.
    rearm(16'h0, 12'd4, 1'b0);
    rx_data = {20'h12345, 32'hAAAA_AAAA, 32'hBBBB_BBBB};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    ckrs.reset = 1'b0;
    tick();
    chk("t7_en", 32'(bram_en_o), 32'h0);
    chk("t7_we", 32'(bram_we_o), 32'h0);
    chk("t7_addr", bram_addr_o, BASE);
    chk("t7_din", bram_din_o, 32'h0);
    chk("t7_status", status_o, 32'h0);
    chk("t7_done", 32'(done_o), 32'h0);
    ckrs.reset = 1'b1;
    tick();
    chk("we_consistency", we_bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mcoi_gbt_frame_capture.md
# mcoi_gbt_frame_capture

Captures received GBT frames into the PS-shared BRAM, so the PS can read a snapshot of the link traffic. Sits downstream of the GBT receiver (120 MHz RX domain) and upstream of the shared-memory BRAM port. It is armed and monitored through one 32-bit control word and one 32-bit status word of the PS shared register. Each 84-bit frame becomes three 32-bit BRAM writes; an optional 16-bit pattern selects the trigger frame.

## Interface
- BASE_ADDR, 32'h0, byte address of the first captured word.
- MAX_FRAMES, 1024, buffer capacity in frames; must be ≤ 4096.
- ClkRs_ix  input  ckrs_t  {clk, reset}: the single clock (GBT RX 120 MHz, also clocks the BRAM port). Reset is synchronous and active-low.
- rx_data_i  input  84  received GBT frame payload.
- rx_valid_i  input  1  one-cycle strobe, nominally 1 in 3 cycles.
- control_i  input  32  PS control word:
  - [0] arm (rising edge);
  - [1] abort (level);
  - [2] trig_en;
  - [15:4] depth in frames;
  - [31:16] trig_value.
- status_o  output  32  status word:
  - [0] armed;
  - [1] capturing;
  - [2] done;
  - [3] overflow (sticky);
  - [15:4] frames_written;
  - [31:16] dropped frames, saturating at 16'hFFFF.
- done_o  output  1  one-cycle pulse on entry to DONE.
- bram_en_o  output  1  BRAM port enable.
- bram_we_o  output  4  byte write enables (all four or none).
- bram_addr_o  output  32  byte address.
- bram_din_o  output  32  write data.

## Operation
- States and transitions:
  - IDLE: entered at reset. An arm rising edge moves to ARMED.
  - ARMED: clears frames_written, dropped and overflow.
    - With trig_en=0, the first rx_valid frame triggers.
    - With trig_en=1, the trigger is rx_valid with rx_data_i[15:0]==trig_value.
    - The trigger frame is itself captured as frame 0, and the state moves to CAPTURE.
  - CAPTURE: frames are accepted until frames_written reaches the effective depth. After the last word of the last frame is written, the state moves to DONE.
  - DONE: holds status; done=1. An arm rising edge moves to ARMED.
  - Arm in ARMED or CAPTURE is ignored.
- Effective depth:
  - depth=0 means MAX_FRAMES.
  - depth>MAX_FRAMES is clamped to MAX_FRAMES.
- Abort (level high) moves any state to IDLE on the next edge and truncates any frame in progress. Counters are kept; done is cleared.
- Arm edge detection compares against the registered previous control_i[0]. The previous value resets to 0.
- Serializer:
  - Holds one frame and emits three write phases, P0, P1 and P2.
  - Words for frame n at word index 3n+k:
    - w0 = data[31:0];
    - w1 = data[63:32];
    - w2 = {n[11:0], data[83:64]}.
  - bram_addr_o = BASE_ADDR + (3n+k)*4 (32-bit arithmetic, no wrap inside the capture).
- Acceptance: a frame is accepted in CAPTURE (or on the trigger) when the serializer is idle or in P2.
- Drops: rx_valid during P0 or P1 drops the frame. A drop increments dropped and sets overflow. The frame being written is unaffected.
- Drops outside CAPTURE are not counted.
- frames_written increments when w2 of a frame is written.

## Timing
- Frame accepted at cycle t: w0 is on the port at t+1, w1 at t+2, w2 at t+3. bram_en_o=1 and bram_we_o=4'hF on those cycles, 0 otherwise.
- Back-to-back: a frame accepted at t+3 gives w0 at t+4. Sustained rate is one frame per 3 cycles with no gaps.
- status_o and done_o are registered, with 1-cycle latency after the causing edge.
- done_o pulses in the cycle after the final w2.
- Reset values:
  - bram_en_o=0, bram_we_o=0, bram_addr_o=BASE_ADDR, bram_din_o=0;
  - status_o=0, done_o=0;
  - state IDLE.
- Reset mid-capture abandons the write immediately.
- Abort and trigger in the same cycle: abort wins.

## Structure
- MCPkg gets:
  - a capture_ctrl_t packed struct (control fields);
  - a capture_status_t packed struct;
  - a capture_state_t enum {IDLE, ARMED, CAPTURE, DONE};
  - the constant GBT_CAP_WORDS_PER_FRAME=3.
- Sub-module mcoi_frame_serializer holds the frame register, 2-bit phase counter, frame index and address generation. It exposes ready (idle or P2), load and word_done/frame_done.

## Test plan
- Capture without trigger:
  - stimulus: trig_en=0, depth=4, arm pulse, frames 84'h1..84'h4 every 3 cycles;
  - response: 12 writes at addresses 0x00–0x2C, w2 of frame 2 = {12'd2, 20'h0}, done_o one pulse, status frames_written=4, dropped=0.
- Pattern trigger:
  - stimulus: trig_en=1, trig_value=16'hA5A5; non-matching frames, then 84'h...A5A5;
  - response: first write at BASE_ADDR carries the match frame; no earlier writes.
- Overflow:
  - stimulus: rx_valid on two consecutive cycles in CAPTURE;
  - response: second frame dropped, overflow=1, dropped=1, first frame written intact.
- Abort mid-frame:
  - stimulus: abort asserted at P1;
  - response: no w2 written, state IDLE next cycle, done=0, bram_en_o=0.
- Depth boundaries:
  - depth=0 with MAX_FRAMES=8 gives exactly 8 frames;
  - depth=4095 with MAX_FRAMES=8 gives 8 frames;
  - re-arm after DONE clears counters and restarts at BASE_ADDR.
- Reset during CAPTURE: all outputs return to reset values on the next edge.
